// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the fetch front end and IF/ID register.
// Instruction field positions, reset values, FSM encoding, IF/ID bundle.
package if_id_stage_pkg;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] PC_STEP_DEF  = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_st_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } if_id_t;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch bus, pipeline control and IF/ID outputs of the fetch stage.
// master = the stage itself, slave = memory / decode environment.
interface if_id_stage_if;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;

  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc4_o;
  logic [5:0]  id_op_o;
  logic [4:0]  id_rs_o;
  logic [4:0]  id_rt_o;
  logic [4:0]  id_rd_o;
  logic [4:0]  id_shamt_o;
  logic [5:0]  id_funct_o;
  logic [15:0] id_imm_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_ack_i, imem_rdata_i,
    input  stall_i, flush_i, redirect_i, redirect_pc_i,
    output id_valid_o, id_instr_o, id_pc4_o,
    output id_op_o, id_rs_o, id_rt_o, id_rd_o,
    output id_shamt_o, id_funct_o, id_imm_o
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_ack_i, imem_rdata_i,
    output stall_i, flush_i, redirect_i, redirect_pc_i,
    input  id_valid_o, id_instr_o, id_pc4_o,
    input  id_op_o, id_rs_o, id_rt_o, id_rd_o,
    input  id_shamt_o, id_funct_o, id_imm_o
  );

endinterface

// File: rtl/if_id_stage_skid.sv
// if_skid_buf: one-entry parking slot for a word fetched while ID stalls.
// clear beats load, load beats drain.
module if_skid_buf
  import if_id_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rstn,
  input  logic   load,
  input  logic   drain,
  input  logic   clear,
  input  if_id_t d,
  output logic   valid,
  output if_id_t q
);

  // Occupancy flag and stored entry
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= 1'b0;
      q     <= '{instr: NOP_INSTR, pc4: 32'h0};
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// MIPS fetch front end: PC, req/ack fetch FSM, skid slot, IF/ID register.
// Optional IF_PERF_CNT_EN adds perf_fetch_o / perf_stall_o counters.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  if_id_stage_if.master bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]  perf_fetch_o,
  output logic [31:0]  perf_stall_o
`endif
);

  fetch_st_e   st_q, st_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] kaddr_q, kaddr_d;
  if_id_t      ifid_q, ifid_d;
  logic        valid_q, valid_d;

  logic        take_fetch;
  logic        skid_load;
  logic        skid_drain;
  logic        skid_clear;
  logic        skid_valid;
  if_id_t      skid_q;
  if_id_t      fetch_word;

  assign fetch_word = '{instr: bus.imem_rdata_i, pc4: pc_q + 32'd4};
  assign skid_clear = bus.flush_i | bus.redirect_i;

  assign bus.imem_req_o  = (st_q == ST_REQ);
  assign bus.imem_addr_o = kill_q ? kaddr_q : pc_q;

  assign bus.id_valid_o = valid_q;
  assign bus.id_instr_o = ifid_q.instr;
  assign bus.id_pc4_o   = ifid_q.pc4;
  assign bus.id_op_o    = ifid_q.instr[OP_HI:OP_LO];
  assign bus.id_rs_o    = ifid_q.instr[RS_HI:RS_LO];
  assign bus.id_rt_o    = ifid_q.instr[RT_HI:RT_LO];
  assign bus.id_rd_o    = ifid_q.instr[RD_HI:RD_LO];
  assign bus.id_shamt_o = ifid_q.instr[SHAMT_HI:SHAMT_LO];
  assign bus.id_funct_o = ifid_q.instr[FUNCT_HI:FUNCT_LO];
  assign bus.id_imm_o   = ifid_q.instr[IMM_HI:IMM_LO];

  if_skid_buf u_skid (
    .clk   (clk),
    .rstn  (rstn),
    .load  (skid_load),
    .drain (skid_drain),
    .clear (skid_clear),
    .d     (fetch_word),
    .valid (skid_valid),
    .q     (skid_q)
  );

  // Fetch FSM next state, PC update and kill tracking
  always_comb begin
    st_d       = st_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    kaddr_d    = kaddr_q;
    take_fetch = 1'b0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    unique case (st_q)
      ST_IDLE: st_d = ST_REQ;
      ST_REQ: begin
        if (bus.imem_ack_i) begin
          kill_d = 1'b0;
          if (!kill_q && !bus.redirect_i) begin
            pc_d       = pc_q + PC_STEP;
            take_fetch = !bus.flush_i && !bus.stall_i;
            if (!bus.flush_i && bus.stall_i) begin
              skid_load = 1'b1;
              st_d      = ST_HOLD;
            end
          end
        end else if (bus.redirect_i) begin
          kill_d = 1'b1;
          if (!kill_q) kaddr_d = pc_q;
        end
      end
      ST_HOLD: begin
        if (bus.flush_i || bus.redirect_i) begin
          st_d = ST_REQ;
        end else if (!bus.stall_i) begin
          skid_drain = skid_valid;
          st_d       = ST_REQ;
        end
      end
      default: st_d = ST_IDLE;
    endcase
    if (bus.redirect_i) pc_d = align_pc(bus.redirect_pc_i);
  end

  // IF/ID register next value: flush > new fetch > skid > stall hold
  always_comb begin
    ifid_d  = ifid_q;
    valid_d = valid_q;
    if (bus.flush_i) begin
      valid_d      = 1'b0;
      ifid_d.instr = NOP_INSTR;
    end else if (take_fetch) begin
      valid_d = 1'b1;
      ifid_d  = fetch_word;
    end else if (skid_drain) begin
      valid_d = 1'b1;
      ifid_d  = skid_q;
    end else if (!bus.stall_i) begin
      valid_d = 1'b0;
    end
  end

  // State, PC and IF/ID registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q    <= ST_IDLE;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      kaddr_q <= RESET_PC;
      ifid_q  <= '{instr: NOP_INSTR, pc4: 32'h0};
      valid_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      kaddr_q <= kaddr_d;
      ifid_q  <= ifid_d;
      valid_q <= valid_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic fetch_inc;
  logic stall_inc;

  assign fetch_inc = take_fetch | skid_drain;
  assign stall_inc = (bus.imem_req_o & ~bus.imem_ack_i)
                   | (st_q == ST_HOLD);

  // Accepted-instruction and fetch-stall cycle counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_fetch_o <= 32'h0;
      perf_stall_o <= 32'h0;
    end else begin
      perf_fetch_o <= perf_fetch_o + {31'd0, fetch_inc};
      perf_stall_o <= perf_stall_o + {31'd0, stall_inc};
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios plus random traffic
// checked every cycle against a transaction-level fetch model.
module tb_if_id_stage;

  logic clk;
  logic rstn;
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;

  if_id_stage_if bus();

  if_id_stage dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_o (perf_fetch),
    .perf_stall_o (perf_stall)
`endif
  );

`ifndef IF_PERF_CNT_EN
  assign perf_fetch = 32'h0;
  assign perf_stall = 32'h0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a fetcher that requests whenever no word is parked,
  // remembers a cancelled in-flight address, and a park queue.
  bit          mdl_on;
  bit          m_idle, m_req, m_dead, m_valid;
  logic [31:0] m_pc, m_dead_addr, m_instr, m_pc4;
  logic [63:0] held[$];
  logic [31:0] m_pf, m_ps;

  task automatic model_reset();
    m_idle = 1; m_req = 0; m_dead = 0; m_valid = 0;
    m_pc = 32'h3000; m_dead_addr = 0; m_instr = 0; m_pc4 = 0;
    held.delete();
    m_pf = 0; m_ps = 0;
  endtask

  task automatic model_step(input logic ak, st, fl, rd,
                            input logic [31:0] rp, dat);
    logic fetched, live, parked;
    logic [31:0] a, pc_old;
    logic [63:0] w;
    fetched = m_req && ak;
    live    = fetched && !m_dead && !rd;
    a       = m_dead ? m_dead_addr : m_pc;
    parked  = held.size() > 0;
    if ((m_req && !ak) || parked) m_ps = m_ps + 1;
    if (fl) begin
      m_valid = 0; m_instr = 0;
    end else if (live && !st) begin
      m_valid = 1; m_instr = dat; m_pc4 = a + 4; m_pf = m_pf + 1;
    end else if (parked && !st && !rd) begin
      w = held.pop_front();
      m_instr = w[63:32]; m_pc4 = w[31:0]; m_valid = 1;
      m_pf = m_pf + 1;
    end else if (!st) begin
      m_valid = 0;
    end
    if (fl || rd) held.delete();
    else if (live && st) held.push_back({dat, a + 32'd4});
    pc_old = m_pc;
    if (rd) m_pc = rp & ~32'd3;
    else if (live) m_pc = m_pc + 4;
    if (m_req && !ak && rd) begin
      if (!m_dead) m_dead_addr = pc_old;
      m_dead = 1;
    end else if (fetched) begin
      m_dead = 0;
    end
    m_req  = m_idle || held.size() == 0;
    m_idle = 0;
  endtask

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (mdl_on) begin
      chk("req", {31'd0, bus.imem_req_o}, {31'd0, m_req});
      if (m_req)
        chk("addr", bus.imem_addr_o, m_dead ? m_dead_addr : m_pc);
      chk("valid", {31'd0, bus.id_valid_o}, {31'd0, m_valid});
      chk("instr", bus.id_instr_o, m_instr);
      chk("pc4", bus.id_pc4_o, m_pc4);
      chk("op_rs_rt", {16'd0, bus.id_op_o, bus.id_rs_o, bus.id_rt_o},
          {16'd0, m_instr[31:16]});
      chk("rd_sh_fn", {16'd0, bus.id_rd_o, bus.id_shamt_o,
          bus.id_funct_o}, {16'd0, m_instr[15:0]});
      chk("imm", {16'd0, bus.id_imm_o}, {16'd0, m_instr[15:0]});
`ifdef IF_PERF_CNT_EN
      chk("perf_fetch", perf_fetch, m_pf);
      chk("perf_stall", perf_stall, m_ps);
`endif
    end
  end

  task automatic step(input logic ak, st, fl, rd,
                      input logic [31:0] rp, dat);
    bus.imem_ack_i    = ak;
    bus.stall_i       = st;
    bus.flush_i       = fl;
    bus.redirect_i    = rd;
    bus.redirect_pc_i = rp;
    bus.imem_rdata_i  = dat;
    model_step(ak, st, fl, rd, rp, dat);
    @(negedge clk);
    #1;
  endtask

  logic [31:0] w4;

  initial begin
    mdl_on = 0;
    model_reset();
    rstn = 1'b0;
    bus.imem_ack_i = 0; bus.stall_i = 0; bus.flush_i = 0;
    bus.redirect_i = 0; bus.redirect_pc_i = 0; bus.imem_rdata_i = 0;
    @(negedge clk); #1;
    chk("rst_req", {31'd0, bus.imem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, bus.id_valid_o}, 32'd0);
    chk("rst_instr", bus.id_instr_o, 32'h0);
    chk("rst_pc4", bus.id_pc4_o, 32'h0);
    chk("rst_f1", {16'd0, bus.id_op_o, bus.id_rs_o, bus.id_rt_o}, 32'd0);
    chk("rst_f2", {bus.id_imm_o, bus.id_rd_o, bus.id_shamt_o,
        bus.id_funct_o}, 32'd0);
    @(negedge clk);
    model_reset();
    rstn = 1'b1;
    mdl_on = 1;
    #1;

    // Back-to-back fetch with ack tied high
    step(1, 0, 0, 0, 0, 32'h0);
    chk("seq_addr0", bus.imem_addr_o, 32'h3000);
    step(1, 0, 0, 0, 0, 32'h2008FFFF);
    chk("seq_addr1", bus.imem_addr_o, 32'h3004);
    chk("seq_pc4_0", bus.id_pc4_o, 32'h3004);
    chk("addi_op", {26'd0, bus.id_op_o}, 32'h08);
    chk("addi_rt", {27'd0, bus.id_rt_o}, 32'd8);
    chk("addi_imm", {16'd0, bus.id_imm_o}, 32'hFFFF);
    step(1, 0, 0, 0, 0, 32'h00021080);
    chk("seq_addr2", bus.imem_addr_o, 32'h3008);
    chk("seq_pc4_1", bus.id_pc4_o, 32'h3008);
    chk("sll_shamt", {27'd0, bus.id_shamt_o}, 32'd2);
    chk("sll_funct", {26'd0, bus.id_funct_o}, 32'd0);
    w4 = $urandom;
    step(1, 0, 0, 0, 0, w4);
    chk("seq_pc4_2", bus.id_pc4_o, 32'h300C);

    // Redirect while a fetch is outstanding: late word is killed
    step(0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 1, 32'h4000, 32'h0);
    chk("kill_addr_hold", bus.imem_addr_o, 32'h300C);
    step(0, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 32'hDEADBEEF);
    chk("kill_new_addr", bus.imem_addr_o, 32'h4000);
    chk("kill_dropped", {31'd0, bus.id_valid_o}, 32'd0);

    // Ack under stall parks the word, released after four cycles
    step(1, 1, 0, 0, 0, 32'h11111111);
    chk("hold_req", {31'd0, bus.imem_req_o}, 32'd0);
    chk("hold_instr", bus.id_instr_o, w4);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 32'h0);
      chk("hold_req_n", {31'd0, bus.imem_req_o}, 32'd0);
    end
    step(0, 0, 0, 0, 0, 32'h0);
    chk("unpark_instr", bus.id_instr_o, 32'h11111111);
    chk("unpark_pc4", bus.id_pc4_o, 32'h4004);
    chk("unpark_addr", bus.imem_addr_o, 32'h4004);
    step(1, 0, 0, 0, 0, 32'h22222222);
    chk("next_instr", bus.id_instr_o, 32'h22222222);
    chk("next_pc4", bus.id_pc4_o, 32'h4008);

    // Flush together with stall
    step(0, 1, 1, 0, 0, 32'h0);
    chk("flush_valid", {31'd0, bus.id_valid_o}, 32'd0);
    chk("flush_instr", bus.id_instr_o, 32'h0);

    // Unaligned redirect with ack, then PC wraps past 2^32
    step(1, 0, 0, 1, 32'hFFFFFFFF, 32'h0);
    chk("wrap_addr", bus.imem_addr_o, 32'hFFFFFFFC);
    step(1, 0, 0, 0, 0, 32'hABCD0123);
    chk("wrap_addr0", bus.imem_addr_o, 32'h0);
    chk("wrap_pc4", bus.id_pc4_o, 32'h0);
    chk("wrap_instr", bus.id_instr_o, 32'hABCD0123);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) < 55, $urandom_range(99) < 25,
           $urandom_range(99) < 8, $urandom_range(99) < 8,
           $urandom, $urandom);
    end

    // Asynchronous reset in the middle of a request
    step(0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    #2;
    mdl_on = 0;
    rstn = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, bus.imem_req_o}, 32'd0);
    chk("mid_rst_addr", bus.imem_addr_o, 32'h3000);
    chk("mid_rst_valid", {31'd0, bus.id_valid_o}, 32'd0);
    @(negedge clk);
    model_reset();
    rstn = 1'b1;
    mdl_on = 1;
    #1;
    step(1, 0, 0, 0, 0, 32'h0);
    chk("post_rst_addr", bus.imem_addr_o, 32'h3000);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, $urandom);

    mdl_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
